// File: rtl/grid_cursor_ctrl.sv
// grid_cursor_ctrl: push-button driven single-cell cursor for an LED-matrix game.
// Turns the four direction keys into single steps with hold-to-repeat, moves the
// cursor over a COLS x ROWS grid (clamp or wrap at the edges), freezes on win/loss
// and drives the one-hot green plane plus the binary position.
// Optional build macro GRID_CURSOR_MOVE_COUNT_EN adds a saturating move_count output.
module grid_cursor_ctrl #(
  parameter int unsigned COLS          = 16,
  parameter int unsigned ROWS          = 16,
  parameter int unsigned START_X       = 8,
  parameter int unsigned START_Y       = 15,
  parameter int unsigned WRAP          = 0,
  parameter int unsigned REPEAT_DELAY  = 25,
  parameter int unsigned REPEAT_PERIOD = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    key,
  input  logic                          win,
  input  logic                          loss,
  output logic [ROWS-1:0][COLS-1:0]     green,
  output logic [$clog2(COLS)-1:0]       pos_x,
  output logic [$clog2(ROWS)-1:0]       pos_y,
`ifdef GRID_CURSOR_MOVE_COUNT_EN
  output logic [15:0]                   move_count,
`endif
  output logic                          movement,
  output logic                          blocked
);

  localparam int unsigned XW       = $clog2(COLS);
  localparam int unsigned YW       = $clog2(ROWS);
  localparam int unsigned CNT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);
  localparam int unsigned DLY_LOAD = (REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1;
  localparam int unsigned PER_LOAD = REPEAT_PERIOD - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    LOCK   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_XM = 2'd0,
    DIR_XP = 2'd1,
    DIR_YM = 2'd2,
    DIR_YP = 2'd3
  } dir_t;

  state_t          state, state_next;
  dir_t            dir_q, dir_next, sel_dir;
  logic [CW-1:0]   cnt, cnt_next;
  logic            step;
  logic [XW-1:0]   x_next;
  logic [YW-1:0]   y_next;
  logic            move_next;
  logic            blk_next;

  // One-hot decode of a cell into the flattened green plane
  function automatic logic [ROWS*COLS-1:0] onehot(input logic [XW-1:0] x,
                                                  input logic [YW-1:0] y);
    logic [ROWS*COLS-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        v[r*COLS+c] = (y == YW'(r)) && (x == XW'(c));
      end
    end
    return v;
  endfunction

  // Key priority: x-1 over x+1 over y-1 over y+1
  always_comb begin
    sel_dir = DIR_YP;
    if (key[0])      sel_dir = DIR_XM;
    else if (key[3]) sel_dir = DIR_XP;
    else if (key[2]) sel_dir = DIR_YM;
    else             sel_dir = DIR_YP;
  end

  // FSM state, latched direction and repeat counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      dir_q <= DIR_XM;
      cnt   <= '0;
    end else begin
      state <= state_next;
      dir_q <= dir_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: press, hold delay, auto-repeat and win/loss freeze
  always_comb begin
    state_next = state;
    dir_next   = dir_q;
    cnt_next   = cnt;
    step       = 1'b0;
    if (win || loss) begin
      state_next = LOCK;
    end else begin
      case (state)
        IDLE: begin
          if (key != 4'b0000) begin
            step       = 1'b1;
            dir_next   = sel_dir;
            cnt_next   = CW'(DLY_LOAD);
            state_next = DELAY;
          end
        end
        DELAY, REPEAT: begin
          if (key == 4'b0000) begin
            state_next = IDLE;
          end else if (sel_dir != dir_q) begin
            step       = 1'b1;
            dir_next   = sel_dir;
            cnt_next   = CW'(DLY_LOAD);
            state_next = DELAY;
          end else if (cnt == '0 && REPEAT_DELAY != 0) begin
            step       = 1'b1;
            cnt_next   = CW'(PER_LOAD);
            state_next = REPEAT;
          end else if (cnt != '0) begin
            cnt_next = cnt - CW'(1);
          end
        end
        LOCK: begin
          // A key still held across the unfreeze must be released first
          if (key == 4'b0000) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Step target: clamp or wrap with explicit compares against the last cell
  always_comb begin
    x_next   = pos_x;
    y_next   = pos_y;
    blk_next = 1'b0;
    if (step) begin
      case (dir_next)
        DIR_XM: begin
          if (pos_x == '0) begin
            if (WRAP != 0) x_next = XW'(COLS - 1);
            else           blk_next = 1'b1;
          end else begin
            x_next = pos_x - XW'(1);
          end
        end
        DIR_XP: begin
          if (pos_x == XW'(COLS - 1)) begin
            if (WRAP != 0) x_next = '0;
            else           blk_next = 1'b1;
          end else begin
            x_next = pos_x + XW'(1);
          end
        end
        DIR_YM: begin
          if (pos_y == '0) begin
            if (WRAP != 0) y_next = YW'(ROWS - 1);
            else           blk_next = 1'b1;
          end else begin
            y_next = pos_y - YW'(1);
          end
        end
        DIR_YP: begin
          if (pos_y == YW'(ROWS - 1)) begin
            if (WRAP != 0) y_next = '0;
            else           blk_next = 1'b1;
          end else begin
            y_next = pos_y + YW'(1);
          end
        end
        default: ;
      endcase
    end
    move_next = step && !blk_next;
  end

  // Registered position, plane and pulses, all updated on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_x    <= XW'(START_X);
      pos_y    <= YW'(START_Y);
      green    <= onehot(XW'(START_X), YW'(START_Y));
      movement <= 1'b0;
      blocked  <= 1'b0;
    end else begin
      pos_x    <= x_next;
      pos_y    <= y_next;
      green    <= onehot(x_next, y_next);
      movement <= move_next;
      blocked  <= blk_next;
    end
  end

`ifdef GRID_CURSOR_MOVE_COUNT_EN
  // Saturating count of movement pulses, bumped on the edge that raises movement
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      move_count <= '0;
    end else if (move_next && move_count != 16'hFFFF) begin
      move_count <= move_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// Bench for grid_cursor_ctrl: two instances (16x16 clamp, 10x6 wrap with repeat off)
// share random key/win/loss stimulus and are compared every cycle to a hold-time model.
module tb_grid_cursor_ctrl;

  localparam int unsigned A_COLS = 16, A_ROWS = 16, A_SX = 8, A_SY = 15, A_WRAP = 0, A_RD = 4, A_RP = 2;
  localparam int unsigned B_COLS = 10, B_ROWS = 6,  B_SX = 9, B_SY = 0,  B_WRAP = 1, B_RD = 0, B_RP = 1;

  logic clk;
  logic reset;
  logic [3:0] key;
  logic win;
  logic loss;

  logic [A_ROWS-1:0][A_COLS-1:0] green_a;
  logic [3:0] pos_x_a;
  logic [3:0] pos_y_a;
  logic movement_a, blocked_a;
  logic [B_ROWS-1:0][B_COLS-1:0] green_b;
  logic [3:0] pos_x_b;
  logic [2:0] pos_y_b;
  logic movement_b, blocked_b;
`ifdef GRID_CURSOR_MOVE_COUNT_EN
  logic [15:0] move_count_a, move_count_b;
`endif

  grid_cursor_ctrl #(
    .COLS(A_COLS), .ROWS(A_ROWS), .START_X(A_SX), .START_Y(A_SY),
    .WRAP(A_WRAP), .REPEAT_DELAY(A_RD), .REPEAT_PERIOD(A_RP)
  ) dut_a (
    .clk(clk), .reset(reset), .key(key), .win(win), .loss(loss),
    .green(green_a), .pos_x(pos_x_a), .pos_y(pos_y_a),
`ifdef GRID_CURSOR_MOVE_COUNT_EN
    .move_count(move_count_a),
`endif
    .movement(movement_a), .blocked(blocked_a)
  );

  grid_cursor_ctrl #(
    .COLS(B_COLS), .ROWS(B_ROWS), .START_X(B_SX), .START_Y(B_SY),
    .WRAP(B_WRAP), .REPEAT_DELAY(B_RD), .REPEAT_PERIOD(B_RP)
  ) dut_b (
    .clk(clk), .reset(reset), .key(key), .win(win), .loss(loss),
    .green(green_b), .pos_x(pos_x_b), .pos_y(pos_y_b),
`ifdef GRID_CURSOR_MOVE_COUNT_EN
    .move_count(move_count_b),
`endif
    .movement(movement_b), .blocked(blocked_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state per instance (0 = A, 1 = B)
  int p_cols[2] = '{A_COLS, B_COLS};
  int p_rows[2] = '{A_ROWS, B_ROWS};
  int p_sx[2]   = '{A_SX, B_SX};
  int p_sy[2]   = '{A_SY, B_SY};
  int p_wrap[2] = '{A_WRAP, B_WRAP};
  int p_rd[2]   = '{A_RD, B_RD};
  int p_rp[2]   = '{A_RP, B_RP};
  int mx[2], my[2], ldir[2], held[2], mcount[2];
  bit holding[2], locked[2], e_mov[2], e_blk[2];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = p_sx[i]; my[i] = p_sy[i];
      ldir[i] = 0; held[i] = 0; mcount[i] = 0;
      holding[i] = 0; locked[i] = 0; e_mov[i] = 0; e_blk[i] = 0;
    end
  endtask

  // One rising edge: a step happens on a fresh press and then at hold times RD, RD+RP, ...
  task automatic model_edge(input logic [3:0] k, input logic w, input logic l);
    for (int i = 0; i < 2; i++) begin
      int dir;
      bit do_step;
      do_step = 0; dir = ldir[i];
      e_mov[i] = 0; e_blk[i] = 0;
      if (w || l) begin
        locked[i] = 1; holding[i] = 0;
      end else if (locked[i]) begin
        if (k == 4'b0000) locked[i] = 0;
      end else if (k == 4'b0000) begin
        holding[i] = 0;
      end else begin
        dir = k[0] ? 0 : k[3] ? 1 : k[2] ? 2 : 3;
        if (!holding[i] || dir != ldir[i]) begin
          holding[i] = 1; ldir[i] = dir; held[i] = 0; do_step = 1;
        end else begin
          held[i]++;
          if (p_rd[i] != 0 && held[i] >= p_rd[i] && ((held[i] - p_rd[i]) % p_rp[i]) == 0)
            do_step = 1;
        end
      end
      if (do_step) begin
        int nx, ny;
        nx = mx[i] + ((dir == 0) ? -1 : (dir == 1) ? 1 : 0);
        ny = my[i] + ((dir == 2) ? -1 : (dir == 3) ? 1 : 0);
        if (nx < 0 || nx >= p_cols[i] || ny < 0 || ny >= p_rows[i]) begin
          if (p_wrap[i] != 0) begin
            nx = (nx + p_cols[i]) % p_cols[i];
            ny = (ny + p_rows[i]) % p_rows[i];
            e_mov[i] = 1;
          end else begin
            nx = mx[i]; ny = my[i];
            e_blk[i] = 1;
          end
        end else begin
          e_mov[i] = 1;
        end
        mx[i] = nx; my[i] = ny;
        if (e_mov[i] && mcount[i] < 65535) mcount[i]++;
      end
    end
  endtask

  function automatic logic [255:0] exp_plane(input int i);
    logic [255:0] v;
    v = '0;
    v[my[i]*p_cols[i] + mx[i]] = 1'b1;
    return v;
  endfunction

  task automatic check_all(input string ph);
    check({ph, " A.pos_x"},    256'(pos_x_a),    256'(mx[0]));
    check({ph, " A.pos_y"},    256'(pos_y_a),    256'(my[0]));
    check({ph, " A.movement"}, 256'(movement_a), 256'(e_mov[0]));
    check({ph, " A.blocked"},  256'(blocked_a),  256'(e_blk[0]));
    check({ph, " A.green"},    256'(green_a),    exp_plane(0));
    check({ph, " B.pos_x"},    256'(pos_x_b),    256'(mx[1]));
    check({ph, " B.pos_y"},    256'(pos_y_b),    256'(my[1]));
    check({ph, " B.movement"}, 256'(movement_b), 256'(e_mov[1]));
    check({ph, " B.blocked"},  256'(blocked_b),  256'(e_blk[1]));
    check({ph, " B.green"},    256'(green_b),    exp_plane(1));
`ifdef GRID_CURSOR_MOVE_COUNT_EN
    check({ph, " A.move_count"}, 256'(move_count_a), 256'(mcount[0]));
    check({ph, " B.move_count"}, 256'(move_count_b), 256'(mcount[1]));
`endif
  endtask

  task automatic drive(input string ph, input logic [3:0] k, input logic w, input logic l, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      key = k; win = w; loss = l;
      @(posedge clk);
      model_edge(k, w, l);
      #1;
      check_all(ph);
    end
  endtask

  // Asynchronous reset mid-cycle, then release with idle inputs
  task automatic pulse_reset();
    @(negedge clk);
    key = 4'b0000; win = 1'b0; loss = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    model_edge(4'b0000, 1'b0, 1'b0);
    #1;
    check_all("rst_release");
  endtask

  initial begin
    reset = 1'b0; key = 4'b0000; win = 1'b0; loss = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("in_reset");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all("after_reset");
    check("reset_green_a", 256'(green_a), 256'(1) << (15*16 + 8));

    // Hold x+1 for 12 cycles: A steps at hold times 0,4,6,8,10; B wraps 9->0 once
    drive("hold_xp", 4'b1000, 1'b0, 1'b0, 12);
    check("hold_x_a", 256'(pos_x_a), 256'(13));
    check("wrap_x_b", 256'(pos_x_b), 256'(0));
    drive("release", 4'b0000, 1'b0, 1'b0, 1);
    drive("single_xm", 4'b0001, 1'b0, 1'b0, 1);
    check("single_x_a", 256'(pos_x_a), 256'(12));
    drive("release", 4'b0000, 1'b0, 1'b0, 1);
    // Long x-1 hold runs A into the left clamp
    drive("clamp_xm", 4'b0001, 1'b0, 1'b0, 40);
    check("clamp_x_a", 256'(pos_x_a), 256'(0));
    drive("release", 4'b0000, 1'b0, 1'b0, 1);
    drive("ym", 4'b0100, 1'b0, 1'b0, 1);
    check("wrap_y_b", 256'(pos_y_b), 256'(5));
    drive("release", 4'b0000, 1'b0, 1'b0, 1);
    drive("yp", 4'b0010, 1'b0, 1'b0, 3);
    drive("release", 4'b0000, 1'b0, 1'b0, 1);
    drive("clamp_yp", 4'b0010, 1'b0, 1'b0, 1);
    drive("release", 4'b0000, 1'b0, 1'b0, 1);
    // Freeze: win while holding, key kept through unfreeze, then a fresh press
    drive("frz_hold", 4'b0100, 1'b0, 1'b0, 3);
    drive("frz_win", 4'b0100, 1'b1, 1'b0, 1);
    drive("frz_held", 4'b0100, 1'b0, 1'b0, 8);
    drive("frz_rel", 4'b0000, 1'b0, 1'b0, 1);
    drive("frz_press", 4'b0100, 1'b0, 1'b0, 1);
    drive("loss", 4'b0000, 1'b0, 1'b1, 2);
    drive("release", 4'b0000, 1'b0, 1'b0, 1);
    pulse_reset();

    // Random segments of held key patterns with occasional win/loss pulses and a reset
    for (int s = 0; s < 300; s++) begin
      logic [3:0] k;
      int len;
      k   = ($urandom_range(0, 9) < 3) ? 4'b0000 : 4'($urandom_range(1, 15));
      len = $urandom_range(1, 14);
      for (int c = 0; c < len; c++) begin
        logic w, l;
        w = ($urandom_range(0, 40) == 0);
        l = ($urandom_range(0, 40) == 0);
        drive("rand", k, w, l, 1);
      end
      if (s == 150) pulse_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
